// File: rtl/rgb2ycbcr_cfg.sv
`default_nettype none
// ============================================================================
// Module      : rgb2ycbcr_cfg
// Description : Four-stage pipelined RGB to YCbCr converter with configurable
//               component width and frame-latched colour-matrix mode.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2ycbcr_cfg #(
    parameter int DW       = 8,
    parameter int MODE_RST = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vsync_in,
    input  logic          hsync_in,
    input  logic          de_in,
    input  logic [DW-1:0] red,
    input  logic [DW-1:0] green,
    input  logic [DW-1:0] blue,
    input  logic [1:0]    cfg_mode,
    output logic          vsync_out,
    output logic          hsync_out,
    output logic          de_out,
    output logic [DW-1:0] y,
    output logic [DW-1:0] cb,
    output logic [DW-1:0] cr,
    output logic [1:0]    mode_active
);

    localparam int PW = DW + 10;
    localparam int SW = DW + 12;

    localparam logic [1:0]           c_MODE_RST   = 2'(MODE_RST);
    localparam logic [1:0]           c_BYPASS     = 2'd3;
    localparam logic [1:0]           c_LIMITED    = 2'd2;
    localparam logic signed [SW-1:0] c_ZERO       = '0;
    localparam logic signed [SW-1:0] c_RND        = SW'(128);
    localparam logic signed [SW-1:0] c_LUMA_OFF   = SW'(16 << (DW - 8));
    localparam logic signed [SW-1:0] c_CHROMA_OFF = SW'(1 << (DW - 1));
    localparam logic signed [SW-1:0] c_MAX        = SW'((1 << DW) - 1);

    // Q0.8 matrices, index = row*3 + column with rows Y/Cb/Cr and columns R/G/B
    localparam logic signed [8:0] c_COEF [0:3][0:8] = '{
        '{ 9'sd77,  9'sd150,  9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21 },
        '{ 9'sd54,  9'sd183,  9'sd19, -9'sd29, -9'sd99, 9'sd128, 9'sd128, -9'sd116, -9'sd12 },
        '{ 9'sd66,  9'sd129,  9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94,  -9'sd18 },
        '{ 9'sd0,   9'sd0,    9'sd0,   9'sd0,   9'sd0,  9'sd0,   9'sd0,    9'sd0,    9'sd0  }
    };

    function automatic logic signed [PW-1:0] f_mul(input logic [DW-1:0] a,
                                                    input logic signed [8:0] c);
        f_mul = $signed({10'b0, a}) * $signed({{(PW-9){c[8]}}, c});
    endfunction

    function automatic logic signed [SW-1:0] f_ext(input logic signed [PW-1:0] p);
        f_ext = {{2{p[PW-1]}}, p};
    endfunction

    function automatic logic [DW-1:0] f_clamp(input logic signed [SW-1:0] t);
        if (t[SW-1])
            f_clamp = '0;
        else if (t > c_MAX)
            f_clamp = {DW{1'b1}};
        else
            f_clamp = t[DW-1:0];
    endfunction

    logic [DW-1:0]        w_pix  [0:2];
    logic signed [PW-1:0] r_prod [0:8];
    logic [DW-1:0]        r_byp1 [0:2];
    logic [DW-1:0]        r_byp2 [0:2];
    logic [1:0]           r_m1;
    logic [1:0]           r_m2;
    logic signed [SW-1:0] r_sum  [0:2];
    logic signed [SW-1:0] w_rnd  [0:2];
    logic signed [SW-1:0] w_shr  [0:2];
    logic signed [SW-1:0] w_off  [0:2];
    logic signed [SW-1:0] w_t    [0:2];
    logic signed [SW-1:0] r_t    [0:2];
    logic [3:0]           r_vs_dly;
    logic [3:0]           r_hs_dly;
    logic [3:0]           r_de_dly;
    logic                 r_vs_d;
    logic [1:0]           r_mode;
    logic [DW-1:0]        r_y;
    logic [DW-1:0]        r_cb;
    logic [DW-1:0]        r_cr;

    assign w_pix[0] = red;
    assign w_pix[1] = green;
    assign w_pix[2] = blue;

    // Mode changes only on a vsync rising edge; the pixel sampled on that
    // same edge still uses the previous mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d <= 1'b0;
            r_mode <= c_MODE_RST;
        end else begin
            r_vs_d <= vsync_in;
            if (vsync_in && !r_vs_d)
                r_mode <= cfg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_dly <= '0;
            r_hs_dly <= '0;
            r_de_dly <= '0;
        end else begin
            r_vs_dly <= {r_vs_dly[2:0], vsync_in};
            r_hs_dly <= {r_hs_dly[2:0], hsync_in};
            r_de_dly <= {r_de_dly[2:0], de_in};
        end
    end

    // Stages 1 and 2: products, then row sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++)
                r_prod[k] <= '0;
            for (int i = 0; i < 3; i++) begin
                r_byp1[i] <= '0;
                r_byp2[i] <= '0;
                r_sum[i]  <= '0;
            end
            r_m1 <= '0;
            r_m2 <= '0;
        end else begin
            for (int k = 0; k < 9; k++)
                r_prod[k] <= f_mul(w_pix[k % 3], c_COEF[r_mode][k]);
            for (int i = 0; i < 3; i++) begin
                r_byp1[i] <= w_pix[i];
                r_byp2[i] <= r_byp1[i];
                r_sum[i]  <= f_ext(r_prod[3*i]) + f_ext(r_prod[3*i+1]) + f_ext(r_prod[3*i+2]);
            end
            r_m1 <= r_mode;
            r_m2 <= r_m1;
        end
    end

    // Stage 3 datapath: round to nearest, arithmetic shift, add offsets
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_rnd[i] = r_sum[i] + c_RND;
            w_shr[i] = w_rnd[i] >>> 8;
            w_off[i] = c_CHROMA_OFF;
            if (i == 0)
                w_off[i] = (r_m2 == c_LIMITED) ? c_LUMA_OFF : c_ZERO;
            w_t[i] = w_shr[i] + w_off[i];
            if (r_m2 == c_BYPASS)
                w_t[i] = $signed({12'b0, r_byp2[i]});
        end
    end

    // Stages 3 and 4; blanking keys off the de bit that lands on de_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                r_t[i] <= '0;
            r_y  <= '0;
            r_cb <= '0;
            r_cr <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                r_t[i] <= w_t[i];
            if (r_de_dly[2]) begin
                r_y  <= f_clamp(r_t[0]);
                r_cb <= f_clamp(r_t[1]);
                r_cr <= f_clamp(r_t[2]);
            end else begin
                r_y  <= '0;
                r_cb <= '0;
                r_cr <= '0;
            end
        end
    end

    assign vsync_out   = r_vs_dly[3];
    assign hsync_out   = r_hs_dly[3];
    assign de_out      = r_de_dly[3];
    assign y           = r_y;
    assign cb          = r_cb;
    assign cr          = r_cr;
    assign mode_active = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_rgb2ycbcr_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb2ycbcr_cfg
// Description : Bench for rgb2ycbcr_cfg at DW=8 and DW=10 against an
//               arithmetic reference model with a 4-deep expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2ycbcr_cfg;

    localparam int c_MR8  = 0;
    localparam int c_MR10 = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs, hs, de;
    logic [11:0] r, g, b;
    logic [1:0]  cfg;

    logic        vso8, hso8, deo8;
    logic [7:0]  y8, cb8, cr8;
    logic [1:0]  m8;
    logic        vso10, hso10, deo10;
    logic [9:0]  y10, cb10, cr10;
    logic [1:0]  m10;

    always #5 clk = ~clk;

    rgb2ycbcr_cfg #(.DW(8), .MODE_RST(c_MR8)) dut8 (
        .clk(clk), .rst_n(rst_n), .vsync_in(vs), .hsync_in(hs), .de_in(de),
        .red(r[7:0]), .green(g[7:0]), .blue(b[7:0]), .cfg_mode(cfg),
        .vsync_out(vso8), .hsync_out(hso8), .de_out(deo8),
        .y(y8), .cb(cb8), .cr(cr8), .mode_active(m8)
    );

    rgb2ycbcr_cfg #(.DW(10), .MODE_RST(c_MR10)) dut10 (
        .clk(clk), .rst_n(rst_n), .vsync_in(vs), .hsync_in(hs), .de_in(de),
        .red(r[9:0]), .green(g[9:0]), .blue(b[9:0]), .cfg_mode(cfg),
        .vsync_out(vso10), .hsync_out(hso10), .de_out(deo10),
        .y(y10), .cb(cb10), .cr(cr10), .mode_active(m10)
    );

    typedef struct {
        logic vs, hs, de;
        int   r, g, b;
        int   m8, m10;
    } rec_t;

    rec_t q[$];
    int   mode8, mode10;
    logic prev_vs;
    int   n_checks = 0;
    int   n_fail   = 0;

    int coef [0:2][0:8] = '{
        '{77, 150, 29, -43, -85, 128, 128, -107, -21},
        '{54, 183, 19, -29, -99, 128, 128, -116, -12},
        '{66, 129, 25, -38, -74, 112, 112, -94,  -18}
    };

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Expected output component from the conversion rules in plain integer math
    function automatic int ref_comp(rec_t e, int dw, int m, int idx);
        int maxv, sum, t;
        int pix [0:2];
        maxv   = (1 << dw) - 1;
        pix[0] = e.r & maxv;
        pix[1] = e.g & maxv;
        pix[2] = e.b & maxv;
        if (!e.de)
            return 0;
        if (m == 3)
            return pix[idx];
        sum = coef[m][3*idx] * pix[0] + coef[m][3*idx+1] * pix[1] + coef[m][3*idx+2] * pix[2];
        t   = (sum + 128) >>> 8;
        if (idx == 0)
            t += (m == 2) ? (16 << (dw - 8)) : 0;
        else
            t += 1 << (dw - 1);
        if (t < 0)
            t = 0;
        if (t > maxv)
            t = maxv;
        return t;
    endfunction

    task automatic compare();
        rec_t e;
        e.vs = 0; e.hs = 0; e.de = 0;
        e.r = 0; e.g = 0; e.b = 0; e.m8 = 0; e.m10 = 0;
        if (q.size() == 4)
            e = q[0];
        check_value("vsync8",  32'(vso8),  32'(e.vs));
        check_value("hsync8",  32'(hso8),  32'(e.hs));
        check_value("de8",     32'(deo8),  32'(e.de));
        check_value("y8",      32'(y8),    ref_comp(e, 8, e.m8, 0));
        check_value("cb8",     32'(cb8),   ref_comp(e, 8, e.m8, 1));
        check_value("cr8",     32'(cr8),   ref_comp(e, 8, e.m8, 2));
        check_value("mode8",   32'(m8),    mode8);
        check_value("vsync10", 32'(vso10), 32'(e.vs));
        check_value("hsync10", 32'(hso10), 32'(e.hs));
        check_value("de10",    32'(deo10), 32'(e.de));
        check_value("y10",     32'(y10),   ref_comp(e, 10, e.m10, 0));
        check_value("cb10",    32'(cb10),  ref_comp(e, 10, e.m10, 1));
        check_value("cr10",    32'(cr10),  ref_comp(e, 10, e.m10, 2));
        check_value("mode10",  32'(m10),   mode10);
    endtask

    task automatic step();
        rec_t e;
        @(posedge clk);
        if (rst_n) begin
            e.vs = vs; e.hs = hs; e.de = de;
            e.r = int'(r); e.g = int'(g); e.b = int'(b);
            e.m8 = mode8; e.m10 = mode10;
            q.push_back(e);
            if (q.size() > 4)
                void'(q.pop_front());
            if (vs && !prev_vs) begin
                mode8  = int'(cfg);
                mode10 = int'(cfg);
            end
            prev_vs = vs;
        end
        #1;
        compare();
    endtask

    task automatic drive(input logic [11:0] rr, input logic [11:0] gg, input logic [11:0] bb,
                         input logic dd, input int n);
        r = rr; g = gg; b = bb; de = dd;
        repeat (n) step();
    endtask

    task automatic pulse_vs(input logic [1:0] c);
        vs = 1'b1; cfg = c;
        step();
        vs = 1'b0;
        step();
    endtask

    task automatic reset_checks();
        check_value("rst_y8",    32'(y8),    0);
        check_value("rst_cb8",   32'(cb8),   0);
        check_value("rst_cr8",   32'(cr8),   0);
        check_value("rst_de8",   32'(deo8),  0);
        check_value("rst_vs8",   32'(vso8),  0);
        check_value("rst_mode8", 32'(m8),    c_MR8);
        check_value("rst_y10",   32'(y10),   0);
        check_value("rst_de10",  32'(deo10), 0);
        check_value("rst_mode10", 32'(m10),  c_MR10);
    endtask

    task automatic random_cycles(input int n);
        repeat (n) begin
            r   = 12'($urandom);
            g   = 12'($urandom);
            b   = 12'($urandom);
            de  = ($urandom_range(0, 3) != 0);
            hs  = ($urandom_range(0, 15) == 0);
            vs  = ($urandom_range(0, 31) == 0);
            cfg = 2'($urandom);
            step();
        end
        vs = 1'b0; hs = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        vs = 0; hs = 0; de = 0; r = 0; g = 0; b = 0; cfg = 0;
        mode8 = c_MR8; mode10 = c_MR10; prev_vs = 1'b0;
        #12;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;

        pulse_vs(2'd0);
        drive(12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 6);
        check_value("white_y8",  32'(y8),   255);
        check_value("white_cb8", 32'(cb8),  128);
        check_value("white_cr8", 32'(cr8),  128);
        check_value("white_y10", 32'(y10),  1023);
        check_value("white_cb10", 32'(cb10), 512);
        check_value("white_cr10", 32'(cr10), 512);

        drive(12'h000, 12'h000, 12'h000, 1'b1, 6);
        check_value("black_y8",  32'(y8),  0);
        check_value("black_cb8", 32'(cb8), 128);
        check_value("black_cr8", 32'(cr8), 128);

        drive(12'hFFF, 12'h000, 12'h000, 1'b1, 6);
        check_value("red_y8",  32'(y8),  77);
        check_value("red_cb8", 32'(cb8), 85);
        check_value("red_cr8", 32'(cr8), 255);

        pulse_vs(2'd2);
        drive(12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 6);
        check_value("lim_y8",  32'(y8),  235);
        check_value("lim_cb8", 32'(cb8), 128);
        check_value("lim_cr8", 32'(cr8), 128);
        cfg = 2'd1;
        drive(12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 6);
        check_value("hold_mode8", 32'(m8), 2);
        check_value("hold_y8",    32'(y8), 235);

        pulse_vs(2'd3);
        drive(12'd10, 12'd20, 12'd30, 1'b1, 6);
        check_value("byp_y8",  32'(y8),  10);
        check_value("byp_cb8", 32'(cb8), 20);
        check_value("byp_cr8", 32'(cr8), 30);
        hs = 1'b1;
        drive(12'd10, 12'd20, 12'd30, 1'b0, 2);
        hs = 1'b0;
        drive(12'd10, 12'd20, 12'd30, 1'b0, 4);
        check_value("blank_y8", 32'(y8), 0);

        pulse_vs(2'd0);
        random_cycles(400);

        // Asynchronous reset in the middle of an active line
        drive(12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 5);
        #3 rst_n = 1'b0;
        #1;
        reset_checks();
        q.delete();
        mode8 = c_MR8; mode10 = c_MR10; prev_vs = 1'b0;
        repeat (2) step();
        #3 rst_n = 1'b1;
        repeat (3) step();
        check_value("post_rst_de8", 32'(deo8), 0);
        step();
        check_value("post_rst_de8_first", 32'(deo8), 1);
        check_value("post_rst_y8_first",  32'(y8),   255);

        random_cycles(150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb2ycbcr_cfg.md
Name: rgb2ycbcr_cfg

Overview:
Parametrised, pipelined RGB→YCbCr converter for the video path, successor to the fixed 8-bit BT.601 converter. Adds:
- configurable component width
- four runtime colour-matrix modes (BT.601 full, BT.709 full, BT.601 limited, bypass), latched only at frame start
- round-to-nearest and output saturation
Sits between the camera/RGB source and the threshold/binarisation stages. Sync signals are delayed to match the data latency.

Parameters:
DW, 8, component width in bits for R/G/B in and Y/Cb/Cr out; legal range 8..12
MODE_RST, 0, conversion mode loaded at reset (0..3)

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
vsync_in  input  1  frame sync, active high
hsync_in  input  1  line sync, active high
de_in  input  1  data enable, active high
red  input  DW  R component, unsigned
green  input  DW  G component, unsigned
blue  input  DW  B component, unsigned
cfg_mode  input  2  requested mode (0 601 full, 1 709 full, 2 601 limited, 3 bypass)
vsync_out  output  1  vsync_in delayed 4 cycles
hsync_out  output  1  hsync_in delayed 4 cycles
de_out  output  1  de_in delayed 4 cycles
y  output  DW  luma
cb  output  DW  blue-difference chroma
cr  output  DW  red-difference chroma
mode_active  output  2  mode currently applied to the pipeline

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers, sync delay lines, y/cb/cr, vsync_out/hsync_out/de_out go to 0. mode_active goes to MODE_RST. Reset applied mid-frame clears in-flight pixels immediately; no partial output after release.
- Mode latch:
  - Register vsync_in once (vs_d). On vsync_in=1 and vs_d=0, mode_active <= cfg_mode on that clock edge.
  - cfg_mode is ignored at all other times.
  - Pixels entering from the next cycle onward use the new mode. Pixels already in flight finish with the mode they entered with, so mode is carried down the pipe per stage.
- Coefficients are Q0.8 (scale 256). Per mode, rows are Y / Cb / Cr, columns are R,G,B:
  - mode 0: Y 77,150,29; Cb -43,-85,128; Cr 128,-107,-21; Yoff 0
  - mode 1: Y 54,183,19; Cb -29,-99,128; Cr 128,-116,-12; Yoff 0
  - mode 2: Y 66,129,25; Cb -38,-74,112; Cr 112,-94,-18; Yoff 16<<(DW-8)
  - mode 3: bypass. y=R, cb=G, cr=B after the same 4-cycle latency; no rounding or offset.
- Pipeline (latency exactly 4 clocks from input sample to output):
  - S1: nine signed products, each DW+10 bits.
  - S2: three signed sums, each DW+12 bits.
  - S3: round and shift. t = (sum + 128) >>> 8 (arithmetic). Add Yoff to Y, add 2^(DW-1) to Cb/Cr.
  - S4: clamp each result to [0, 2^DW-1], register.
- Blanking: y/cb/cr are forced to 0 in any cycle where de_out=0. This replaces the old hsync gating.
- Throughput: one pixel per clock, no stalls, no backpressure.
- Sync delay lines are 4 deep and independent of mode. A vsync edge at the input appears at vsync_out exactly 4 cycles later.
- cfg_mode change and vsync rise on the same edge: the new value is latched.

Test Plan:
- DW=8, mode 0, de=1, RGB=(255,255,255) → after 4 clk: Y=255, Cb=128, Cr=128. RGB=(0,0,0) → 0,128,128.
- DW=8, mode 0, RGB=(255,0,0) → Y=77, Cb=85, Cr=255. The raw Cr of 256 must saturate to 255.
- DW=8: pulse vsync with cfg_mode=2, then RGB=(255,255,255) → Y=235, Cb=128, Cr=128. Then set cfg_mode=1 without vsync → mode_active stays 2 and outputs are unchanged until the next vsync rise.
- Bypass (mode 3), RGB=(10,20,30) → y=10, cb=20, cr=30 at latency 4. de_in=0 → outputs 0 while syncs still propagate with 4-cycle delay.
- DW=10, mode 0, RGB=(1023,1023,1023) → Y=1023, Cb=512, Cr=512. Back-to-back pixels each clock → matching back-to-back outputs.
- Assert rst_n low mid-line with de active → all outputs 0 asynchronously and mode_active=MODE_RST. After release, first valid output appears 4 clocks after the first de_in=1 sample.
